// File: rtl/fsm_transmissor_periferico.sv
// ============================================================================
// fsm_transmissor_periferico
// ----------------------------------------------------------------------------
// Processor-side transmitter for the 16-bit peripheral link. Words written by
// the core are buffered in a small circular FIFO. Each word is then pushed to
// the peripheral with a four-phase handshake:
//   IDLE -> REQ : o_send = 01 with o_dado valid
//   REQ  -> REL : peripheral answers ack = 01, o_send drops to 00
//   REL  -> IDLE: peripheral releases ack = 00, word counted and popped
// A per-phase timer aborts a handshake that stalls in REQ or REL. Sticky error
// flags report timeouts and dropped writes.
//
// Parameters
//   DEPTH    FIFO entries, power of two, 2..16
//   TIMEOUT  cycles allowed in one handshake phase, 1..255
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   i_wr_en        write strobe from the core
//   i_wr_data      word to transmit
//   o_full         FIFO holds DEPTH words
//   o_empty        FIFO holds no words
//   o_dado         data to the peripheral (held while IDLE)
//   o_send         request code: 00 idle, 01 data valid
//   i_ack          peripheral response: 01 accepted, 00 released
//   o_busy         FSM is in REQ or REL
//   o_sent_count   completed handshakes, wraps 255 -> 0
//   o_timeout_err  sticky: a handshake phase timed out
//   o_overflow     sticky: a write arrived while full
//   i_err_clr      clears both sticky flags
// ============================================================================
module fsm_transmissor_periferico #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [15:0] i_wr_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [15:0] o_dado,
    output logic [1:0]  o_send,
    input  logic [1:0]  i_ack,
    output logic        o_busy,
    output logic [7:0]  o_sent_count,
    output logic        o_timeout_err,
    output logic        o_overflow,
    input  logic        i_err_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    // The timer counts completed edges in a phase; the edge that would make
    // it reach TIMEOUT is the one that fires the abort.
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] SEND_IDLE   = 2'b00;
    localparam logic [1:0] SEND_VALID  = 2'b01;
    localparam logic [1:0] ACK_ACCEPT  = 2'b01;
    localparam logic [1:0] ACK_RELEASE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;

    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [7:0]      r_timer;
    logic [15:0]     r_dado;
    logic [1:0]      r_send;
    logic [7:0]      r_sent_count;
    logic            r_timeout_err;
    logic            r_overflow;

    // ------------------------------------------------------------------
    // FIFO status and write qualification
    // ------------------------------------------------------------------
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_drop;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    // A write while full is discarded even if the head pops on the same
    // edge: the core saw o_full and the word is reported as lost.
    assign w_push  = i_wr_en && !w_full;
    assign w_drop  = i_wr_en &&  w_full;

    // ------------------------------------------------------------------
    // FSM next-state and registered-output values
    // ------------------------------------------------------------------
    logic [15:0]     w_dado_nxt;
    logic [1:0]      w_send_nxt;
    logic [7:0]      w_timer_nxt;
    logic            w_pop;
    logic            w_done;
    logic            w_tmo;

    // NOTE: every signal gets a default before the case, so no path through
    // this block leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_dado_nxt  = r_dado;
        w_send_nxt  = SEND_IDLE;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_dado_nxt  = r_mem[r_rd_ptr];
                    w_send_nxt  = SEND_VALID;
                    w_timer_nxt = '0;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                w_send_nxt = SEND_VALID;
                if (i_ack == ACK_ACCEPT) begin
                    w_send_nxt  = SEND_IDLE;
                    w_timer_nxt = '0;
                    w_state_nxt = S_REL;
                end else if (r_timer == TMO_LAST) begin
                    // Abandon the word so one dead transfer cannot block
                    // the rest of the queue.
                    w_send_nxt  = SEND_IDLE;
                    w_tmo       = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end

            S_REL: begin
                if (i_ack == ACK_RELEASE) begin
                    w_pop       = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == TMO_LAST) begin
                    w_tmo       = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs, timer and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dado       <= '0;
            r_send       <= SEND_IDLE;
            r_timer      <= '0;
            r_sent_count <= '0;
        end else begin
            r_dado  <= w_dado_nxt;
            r_send  <= w_send_nxt;
            r_timer <= w_timer_nxt;
            if (w_done) begin
                r_sent_count <= r_sent_count + 8'd1;
            end
        end
    end

    // Sticky error flags: a new event on the same edge beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers decide
    // what is valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_dado        = r_dado;
    assign o_send        = r_send;
    assign o_busy        = (r_state != S_IDLE);
    assign o_sent_count  = r_sent_count;
    assign o_timeout_err = r_timeout_err;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_fsm_transmissor_periferico.sv
// ============================================================================
// tb_fsm_transmissor_periferico
// ----------------------------------------------------------------------------
// Self-checking bench for fsm_transmissor_periferico (DEPTH = 4, TIMEOUT = 8).
// Accepted writes are pushed to a scoreboard queue; a monitor pops the queue
// each time a handshake starts and compares o_dado, and also checks that
// o_dado is held during REQ/REL. A behavioural responder selected by `mode`
// drives i_ack. Inputs change and outputs are sampled on the falling edge.
// ============================================================================
module tb_fsm_transmissor_periferico;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        err_clr = 1'b0;
    logic [1:0]  ack;

    logic        o_full;
    logic        o_empty;
    logic [15:0] o_dado;
    logic [1:0]  o_send;
    logic        o_busy;
    logic [7:0]  o_sent_count;
    logic        o_timeout_err;
    logic        o_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder: 0 = stalled (ack 00), 1 = immediate four-phase,
    //            2 = stuck at 01, 3 = garbage 10
    int mode = 0;

    logic [15:0] sb_q [$];

    fsm_transmissor_periferico #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_dado        (o_dado),
        .o_send        (o_send),
        .i_ack         (ack),
        .o_busy        (o_busy),
        .o_sent_count  (o_sent_count),
        .o_timeout_err (o_timeout_err),
        .o_overflow    (o_overflow),
        .i_err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       ack = 2'b00;
            1:       ack = (o_send == 2'b01) ? 2'b01 : 2'b00;
            2:       ack = 2'b01;
            default: ack = 2'b10;
        endcase
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          last_rise = 0;
    int          n_rises = 0;
    bit          b2b_on = 1'b0;
    logic [15:0] cur_word = 16'h0000;
    logic [1:0]  prev_send = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_send == 2'b01 && prev_send != 2'b01) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_word: got dado %h with no word queued", o_dado);
                end else begin
                    cur_word = sb_q.pop_front();
                    if (o_dado !== cur_word) begin
                        n_fail++;
                        $display("FAIL sb_word: got %h want %h", o_dado, cur_word);
                    end
                end
                if (b2b_on) begin
                    n_tests++;
                    if (o_sent_count !== 8'(n_rises)) begin
                        n_fail++;
                        $display("FAIL b2b_count: got %0d want %0d", o_sent_count, 8'(n_rises));
                    end
                    if (n_rises > 0) begin
                        n_tests++;
                        if (cyc - last_rise != 3) begin
                            n_fail++;
                            $display("FAIL b2b_gap: got %0d cycles want 3", cyc - last_rise);
                        end
                    end
                    last_rise = cyc;
                    n_rises++;
                end
            end else if (o_busy) begin
                n_tests++;
                if (o_dado !== cur_word) begin
                    n_fail++;
                    $display("FAIL dado_hold: got %h want %h", o_dado, cur_word);
                end
            end
        end
        prev_send = o_send;
    end

    // ------------------------------------------------------------------
    // Helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic write_word(input logic [15:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        if (accept) sb_q.push_back(d);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(o_empty && !o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!(o_empty && !o_busy)) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy %b empty %b after %0d cycles", name, o_busy, o_empty, n);
        end
    endtask

    task automatic wait_send_valid(input int budget, input string name);
        int n = 0;
        while (o_send != 2'b01 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (o_send !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_send_timeout: send %b after %0d cycles", name, o_send, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        n_tests += 8;
        if (o_send !== 2'b00)        begin n_fail++; $display("FAIL reset_send: got %b want 00", o_send); end
        if (o_dado !== 16'h0000)     begin n_fail++; $display("FAIL reset_dado: got %h want 0000", o_dado); end
        if (o_busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        if (o_sent_count !== 8'd0)   begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_sent_count); end
        if (o_timeout_err !== 1'b0)  begin n_fail++; $display("FAIL reset_tmo: got %b want 0", o_timeout_err); end
        if (o_overflow !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        if (o_empty !== 1'b1)        begin n_fail++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        if (o_full !== 1'b0)         begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
    endtask

    task automatic test_single_word();
        mode = 1;
        write_word(16'hA5C3, 1'b1);
        n_tests += 2;
        if (o_send !== 2'b00) begin n_fail++; $display("FAIL single_latency0: got send %b want 00", o_send); end
        if (o_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", o_empty); end
        @(negedge clk);
        n_tests += 3;
        if (o_send !== 2'b01)     begin n_fail++; $display("FAIL single_send: got %b want 01", o_send); end
        if (o_dado !== 16'hA5C3)  begin n_fail++; $display("FAIL single_dado: got %h want a5c3", o_dado); end
        if (o_busy !== 1'b1)      begin n_fail++; $display("FAIL single_busy: got %b want 1", o_busy); end
        wait_idle(50, "single");
        n_tests += 4;
        if (o_sent_count !== 8'd1)   begin n_fail++; $display("FAIL single_count: got %0d want 1", o_sent_count); end
        if (o_timeout_err !== 1'b0)  begin n_fail++; $display("FAIL single_tmo: got %b want 0", o_timeout_err); end
        if (o_busy !== 1'b0)         begin n_fail++; $display("FAIL single_idle: got %b want 0", o_busy); end
        if (o_dado !== 16'hA5C3)     begin n_fail++; $display("FAIL single_dado_idle: got %h want a5c3", o_dado); end
    endtask

    task automatic test_overflow();
        mode = 0;
        for (int i = 1; i <= 4; i++) write_word(16'(i), 1'b1);
        n_tests += 2;
        if (o_full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full4: got %b want 1", o_full); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
        write_word(16'd5, 1'b0);
        n_tests += 2;
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
        if (o_full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full5: got %b want 1", o_full); end
        // A new drop on the same edge as err_clr keeps the flag set.
        err_clr = 1'b1;
        write_word(16'd6, 1'b0);
        err_clr = 1'b0;
        n_tests++;
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", o_overflow); end
        pulse_err_clr();
        n_tests++;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", o_overflow); end
        mode = 1;
        wait_idle(100, "ovf");
        n_tests += 2;
        if (o_sent_count !== 8'd5)  begin n_fail++; $display("FAIL ovf_count: got %0d want 5", o_sent_count); end
        if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL ovf_tmo: got %b want 0", o_timeout_err); end
    endtask

    task automatic test_timeout_req();
        int n = 0;
        mode = 3;
        write_word(16'h1111, 1'b1);
        write_word(16'h2222, 1'b1);
        wait_send_valid(10, "tmo_req");
        while (o_send == 2'b01 && n < 50) begin
            n++;
            @(negedge clk);
        end
        n_tests += 5;
        if (n != TIMEOUT)           begin n_fail++; $display("FAIL tmo_req_len: got %0d cycles want %0d", n, TIMEOUT); end
        if (o_timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_req_err: got %b want 1", o_timeout_err); end
        if (o_sent_count !== 8'd5)  begin n_fail++; $display("FAIL tmo_req_count: got %0d want 5", o_sent_count); end
        if (o_busy !== 1'b0)        begin n_fail++; $display("FAIL tmo_req_idle: got %b want 0", o_busy); end
        if (o_empty !== 1'b0)       begin n_fail++; $display("FAIL tmo_req_next_queued: got empty %b want 0", o_empty); end
        @(negedge clk);
        n_tests++;
        if (o_send !== 2'b01) begin n_fail++; $display("FAIL tmo_req_next_start: got %b want 01", o_send); end
        mode = 1;
        wait_idle(50, "tmo_req");
        n_tests++;
        if (o_sent_count !== 8'd6) begin n_fail++; $display("FAIL tmo_req_count2: got %0d want 6", o_sent_count); end
        pulse_err_clr();
        n_tests++;
        if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_req_clr: got %b want 0", o_timeout_err); end
    endtask

    task automatic test_timeout_rel();
        int n = 0;
        mode = 2;
        write_word(16'h3333, 1'b1);
        wait_send_valid(10, "tmo_rel");
        @(negedge clk);
        n_tests++;
        if (o_send !== 2'b00 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_rel_enter: got send %b busy %b want 00 1", o_send, o_busy);
        end
        while (o_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        n_tests += 4;
        if (n != TIMEOUT)           begin n_fail++; $display("FAIL tmo_rel_len: got %0d cycles want %0d", n, TIMEOUT); end
        if (o_timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_rel_err: got %b want 1", o_timeout_err); end
        if (o_sent_count !== 8'd6)  begin n_fail++; $display("FAIL tmo_rel_count: got %0d want 6", o_sent_count); end
        if (o_empty !== 1'b1)       begin n_fail++; $display("FAIL tmo_rel_popped: got empty %b want 1", o_empty); end
        pulse_err_clr();
        n_tests++;
        if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_rel_clr: got %b want 0", o_timeout_err); end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        mode = 0;
        write_word(16'h4441, 1'b1);
        write_word(16'h4442, 1'b1);
        write_word(16'h4443, 1'b1);
        n_tests++;
        if (o_send !== 2'b01) begin n_fail++; $display("FAIL rstmid_in_req: got send %b want 01", o_send); end
        rst = 1'b1;
        @(negedge clk);
        n_tests += 6;
        if (o_send !== 2'b00)       begin n_fail++; $display("FAIL rstmid_send: got %b want 00", o_send); end
        if (o_dado !== 16'h0000)    begin n_fail++; $display("FAIL rstmid_dado: got %h want 0000", o_dado); end
        if (o_empty !== 1'b1)       begin n_fail++; $display("FAIL rstmid_empty: got %b want 1", o_empty); end
        if (o_busy !== 1'b0)        begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        if (o_sent_count !== 8'd0)  begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", o_sent_count); end
        if (o_full !== 1'b0)        begin n_fail++; $display("FAIL rstmid_full: got %b want 0", o_full); end
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_stays_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        mode    = 1;
        n_rises = 0;
        b2b_on  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int g = 0;
            while (o_full && g < 100) begin
                @(negedge clk);
                g++;
            end
            write_word(16'(16'hB000 + i), 1'b1);
        end
        wait_idle(200, "b2b");
        b2b_on = 1'b0;
        n_tests += 3;
        if (o_sent_count !== 8'd0)  begin n_fail++; $display("FAIL b2b_wrap: got %0d want 0", o_sent_count); end
        if (n_rises != 256)         begin n_fail++; $display("FAIL b2b_words: got %0d want 256", n_rises); end
        if (sb_q.size() != 0)       begin n_fail++; $display("FAIL b2b_leftover: got %0d queued want 0", sb_q.size()); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single_word();
        test_overflow();
        test_timeout_req();
        test_timeout_rel();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_transmissor_periferico.md
# fsm_transmissor_periferico

Processor-side transmitter for the 16-bit peripheral link: it buffers words handed over by the datapath and pushes each one to the peripheral over the `dado`/`send`/`ack` four-phase handshake. It sits between the processor core's output-write path and peripheral 1. It owns the initiator end of the protocol: it drives `dado` and `send` and samples the peripheral's `ack`. A small FIFO, a per-phase timeout, and status counters make it robust to a slow or dead peripheral.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `TIMEOUT`, 255: maximum cycles spent waiting in one handshake phase, 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write strobe from the core.
- `wr_data`  in  16  word to transmit.
- `full`  out  1  FIFO holds `DEPTH` words.
- `empty`  out  1  FIFO holds 0 words.
- `dado`  out  16  data to the peripheral.
- `send`  out  2  request code: 2'b00 = idle, 2'b01 = data valid.
- `ack`  in  2  peripheral response: 2'b01 = accepted, 2'b00 = released.
- `busy`  out  1  FSM is not in IDLE.
- `sent_count`  out  8  words successfully handshaken; wraps from 255 to 0.
- `timeout_err`  out  1  sticky: a handshake phase timed out.
- `overflow`  out  1  sticky: a write arrived while `full`.
- `err_clr`  in  1  clears `timeout_err` and `overflow`.

## Operation
- FIFO: circular buffer with `DEPTH` entries and an occupancy counter.
  - A write while full is dropped and sets `overflow`.
  - A write and a pop in the same cycle are both performed; occupancy is unchanged.
- FSM states: IDLE, REQ, REL.
- **IDLE**: `send` = 00.
  - If the FIFO is not empty: load `dado` from the FIFO head, set `send` = 01, clear the timer, go to REQ.
- **REQ**: `send` = 01; `dado` is held stable.
  - `ack` == 01: `send` = 00, clear the timer, go to REL.
  - Otherwise the timer increments. When the timer equals `TIMEOUT`: set `timeout_err`, pop the word, `send` = 00, go to IDLE.
- **REL**: `send` = 00; `dado` is still held.
  - `ack` == 00: pop the word, increment `sent_count`, go to IDLE.
  - Otherwise the timer increments. On reaching `TIMEOUT`: set `timeout_err`, pop the word (`sent_count` is not incremented), go to IDLE.
- `ack` values 10 and 11 are treated as "not 01" in REQ and "not 00" in REL.
- The FIFO head is popped only when its handshake finishes or times out.
- `err_clr`: if it coincides with a new error event in the same cycle, the set wins.
- `dado` keeps its last transmitted value while IDLE.

## Timing
- Reset values: `send` = 00, `dado` = 0, `busy` = 0, `sent_count` = 0, `timeout_err` = 0, `overflow` = 0, `empty` = 1, `full` = 0, FSM in IDLE, FIFO emptied.
- Reset applies on the next edge and overrides everything, including mid-handshake: `send` drops to 00 and buffered words are discarded.
- All outputs are registered; `ack` is sampled directly (same clock domain, no synchronizer).
- Latency: `wr_en` sampled at edge k on an empty FIFO in IDLE gives `send` = 01 and a valid `dado` after edge k+1.
- `ack` = 01 sampled at edge m gives `send` = 00 after edge m.
- `ack` = 00 sampled at edge n gives IDLE, `sent_count` incremented, and the pop after edge n. The next word's `send` = 01 follows after edge n+1.
- Back-to-back throughput with a responder that answers on the first sampled cycle: one word per 3 cycles.
- Timeout: the phase's timeout action occurs on the `TIMEOUT`-th edge after entering REQ or REL.
- `full`, `empty`, and `busy` reflect post-edge state.

## Test plan
- Single word 16'hA5C3, responder acks one cycle after `send` = 01 and releases one cycle after `send` = 00.
  - Required: `dado` = A5C3 for the whole handshake, `sent_count` 0 -> 1, `busy` back to 0, `timeout_err` = 0.
- Write 5 words (1..5) on consecutive cycles with `DEPTH` = 4 and a stalled responder.
  - Required: `full` = 1 after 4 writes, `overflow` = 1, and words 1..4 are transmitted in order once the responder runs.
- `ack` held 00 with `TIMEOUT` = 8.
  - Required: `send` = 01 for 8 cycles, then 00, `timeout_err` = 1, word popped, `sent_count` unchanged, next word starts.
- `ack` stuck at 01 in REL with `TIMEOUT` = 8.
  - Required: `timeout_err` = 1 after 8 cycles, IDLE, `sent_count` unchanged.
  - Then pulse `err_clr`: `timeout_err` = 0.
- Assert `rst` while in REQ with 3 words queued.
  - Required: next cycle `send` = 00, `dado` = 0, `empty` = 1, `busy` = 0, `sent_count` = 0.
- 256 immediate-response handshakes.
  - Required: `sent_count` wraps to 0, and each word takes exactly 3 cycles.
